// File: rtl/seq_ctrl_pkg.sv
// Shared types, sizing constants and helpers for the programmable step sequencer.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int DEF_DEPTH = 8;
  localparam int IDX_W     = $clog2(DEF_DEPTH);
  localparam int LEN_W     = IDX_W + 1;

  // A run must cover at least one entry and never more than the table holds.
  function automatic logic len_ok(input int unsigned len, input int unsigned depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module seq_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/seq_step_controller.sv
// Programmable step sequencer: walks the first len table entries over valid/ready,
// repeating the pass a programmed number of times or forever.
module seq_step_controller
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LOOP_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0] i_cfg_addr,
  input  logic [WIDTH-1:0]         i_cfg_data,
  input  logic [$clog2(DEPTH):0]   i_cfg_len,
  input  logic [LOOP_W-1:0]        i_cfg_loops,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH-1:0]         o_dataout,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cfg_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [LW-1:0]     r_len;
  logic [LOOP_W-1:0] r_loops;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  logic              w_tab_we;
  logic [WIDTH-1:0]  w_rd_data;
  logic              w_last_idx;
  logic              w_last_pass;
  logic              w_len_ok;

  // The table is only writable while idle, so a running pass never sees a torn update.
  assign w_tab_we    = i_cfg_we && (r_state == ST_IDLE);
  assign w_last_idx  = ({1'b0, r_idx} == (r_len - LW'(1)));
  assign w_last_pass = (r_loops != '0) && (r_loop_cnt == (r_loops - LOOP_W'(1)));
  assign w_len_ok    = len_ok(32'(i_cfg_len), 32'(DEPTH));

  seq_table #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_table (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_we   (w_tab_we),
    .i_waddr(i_cfg_addr),
    .i_wdata(i_cfg_data),
    .i_raddr(r_idx),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_loops     <= '0;
      r_loop_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            if (w_len_ok) begin
              r_len       <= i_cfg_len;
              r_loops     <= i_cfg_loops;
              r_idx       <= '0;
              r_loop_cnt  <= '0;
              r_state     <= ST_RUN;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_cfg_err <= i_cfg_we;
          // A beat accepted alongside stop has already been handed to the consumer.
          if (i_stop) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else if (i_out_ready) begin
            if (!w_last_idx) begin
              r_idx <= r_idx + AW'(1);
            end else if (w_last_pass) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx <= '0;
              if (r_loop_cnt != {LOOP_W{1'b1}}) begin
                r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          r_cfg_err <= i_cfg_we;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_dataout   = r_out_valid ? w_rd_data : '0;

endmodule

// File: tb/tb_seq_step_controller.sv
// Directed self-checking bench for seq_step_controller with hand-computed expectations.
module tb_seq_step_controller;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_cfg_we;
  logic [2:0] i_cfg_addr;
  logic [3:0] i_cfg_data;
  logic [3:0] i_cfg_len;
  logic [7:0] i_cfg_loops;
  logic       i_start;
  logic       i_stop;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [3:0] o_dataout;
  logic       o_busy;
  logic       o_done;
  logic       o_cfg_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] seqv [6] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd11, 4'd14};

  seq_step_controller #(
    .WIDTH (4),
    .DEPTH (8),
    .LOOP_W(8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_data (i_cfg_data),
    .i_cfg_len  (i_cfg_len),
    .i_cfg_loops(i_cfg_loops),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_dataout  (o_dataout),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_cfg_err  (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock and settle just past the rising edge before sampling.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(o_out_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(o_busy),      32'd0);
    checkOutput({tag, "_data"},  32'(o_dataout),   32'd0);
  endtask

  task automatic startRun(input logic [3:0] len, input logic [7:0] loops);
    i_cfg_len   = len;
    i_cfg_loops = loops;
    i_start     = 1'b1;
    applyStimulus();
    i_start     = 1'b0;
  endtask

  initial begin
    i_reset     = 1'b1;
    i_cfg_we    = 1'b0;
    i_cfg_addr  = '0;
    i_cfg_data  = '0;
    i_cfg_len   = '0;
    i_cfg_loops = '0;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_out_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    checkIdle("reset");
    checkOutput("reset_done", 32'(o_done),    32'd0);
    checkOutput("reset_err",  32'(o_cfg_err), 32'd0);
    i_reset = 1'b0;
    applyStimulus();

    $display("[TB] test 1: infinite loop over six entries");
    for (int a = 0; a < 6; a++) begin
      i_cfg_we   = 1'b1;
      i_cfg_addr = 3'(a);
      i_cfg_data = seqv[a];
      applyStimulus();
    end
    i_cfg_we    = 1'b0;
    i_out_ready = 1'b1;
    startRun(4'd6, 8'd0);
    checkOutput("t1_valid", 32'(o_out_valid), 32'd1);
    checkOutput("t1_busy",  32'(o_busy),      32'd1);
    for (int k = 0; k < 14; k++) begin
      checkOutput($sformatf("t1_data%0d", k), 32'(o_dataout), 32'(seqv[k % 6]));
      checkOutput($sformatf("t1_done%0d", k), 32'(o_done),    32'd0);
      applyStimulus();
    end
    i_stop = 1'b1;
    applyStimulus();
    i_stop = 1'b0;
    checkIdle("t1_stop");
    checkOutput("t1_stop_done", 32'(o_done), 32'd0);

    $display("[TB] test 2: two finite passes");
    startRun(4'd6, 8'd2);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("t2_valid%0d", k), 32'(o_out_valid), 32'd1);
      checkOutput($sformatf("t2_data%0d", k),  32'(o_dataout),   32'(seqv[k % 6]));
      checkOutput($sformatf("t2_done%0d", k),  32'(o_done),      32'd0);
      applyStimulus();
    end
    checkOutput("t2_done_pulse", 32'(o_done), 32'd1);
    checkIdle("t2_done_state");
    applyStimulus();
    checkOutput("t2_done_clear", 32'(o_done), 32'd0);
    checkIdle("t2_after");

    $display("[TB] test 3: backpressure stalls");
    startRun(4'd3, 8'd1);
    checkOutput("t3_b0", 32'(o_dataout), 32'd0);
    applyStimulus();
    checkOutput("t3_b1", 32'(o_dataout), 32'd2);
    applyStimulus();
    checkOutput("t3_b2", 32'(o_dataout), 32'd5);
    i_out_ready = 1'b0;
    applyStimulus();
    checkOutput("t3_stall1", 32'(o_dataout),   32'd5);
    checkOutput("t3_stall1_v", 32'(o_out_valid), 32'd1);
    applyStimulus();
    checkOutput("t3_stall2", 32'(o_dataout),   32'd5);
    i_out_ready = 1'b1;
    applyStimulus();
    checkOutput("t3_done", 32'(o_done), 32'd1);
    applyStimulus();

    $display("[TB] test 4: rejected writes and starts");
    startRun(4'd6, 8'd2);
    checkOutput("t4_b0", 32'(o_dataout), 32'd0);
    i_cfg_we   = 1'b1;
    i_cfg_addr = 3'd0;
    i_cfg_data = 4'd9;
    applyStimulus();
    i_cfg_we = 1'b0;
    checkOutput("t4_err", 32'(o_cfg_err), 32'd1);
    checkOutput("t4_b1",  32'(o_dataout), 32'd2);
    applyStimulus();
    checkOutput("t4_err_clear", 32'(o_cfg_err), 32'd0);
    repeat (4) applyStimulus();
    checkOutput("t4_pass2_first", 32'(o_dataout), 32'd0);
    i_stop = 1'b1;
    applyStimulus();
    i_stop = 1'b0;
    startRun(4'd0, 8'd1);
    checkOutput("t4_len0_err", 32'(o_cfg_err), 32'd1);
    checkIdle("t4_len0");
    startRun(4'd9, 8'd1);
    checkOutput("t4_len9_err", 32'(o_cfg_err), 32'd1);
    checkIdle("t4_len9");
    i_stop = 1'b1;
    startRun(4'd6, 8'd1);
    i_stop = 1'b0;
    checkOutput("t4_startstop_err", 32'(o_cfg_err), 32'd0);
    checkIdle("t4_startstop");

    $display("[TB] test 5: stop mid-run then restart");
    startRun(4'd6, 8'd0);
    checkOutput("t5_b0", 32'(o_dataout), 32'd0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t5_b3", 32'(o_dataout), 32'd7);
    i_stop = 1'b1;
    applyStimulus();
    i_stop = 1'b0;
    checkIdle("t5_stop");
    checkOutput("t5_stop_done", 32'(o_done), 32'd0);
    applyStimulus();
    checkOutput("t5_stop_done2", 32'(o_done), 32'd0);
    startRun(4'd6, 8'd0);
    checkOutput("t5_restart", 32'(o_dataout), 32'd0);
    applyStimulus();
    checkOutput("t5_restart1", 32'(o_dataout), 32'd2);

    $display("[TB] test 6: asynchronous reset mid-run");
    applyStimulus();
    checkOutput("t6_pre", 32'(o_dataout), 32'd5);
    #3;
    i_reset = 1'b1;
    #1;
    checkIdle("t6_async");
    #2;
    i_reset = 1'b0;
    applyStimulus();
    checkOutput("t6_after_done", 32'(o_done), 32'd0);
    startRun(4'd6, 8'd1);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t6_valid%0d", k), 32'(o_out_valid), 32'd1);
      checkOutput($sformatf("t6_zero%0d", k),  32'(o_dataout),   32'd0);
      applyStimulus();
    end
    checkOutput("t6_done", 32'(o_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
